// File: rtl/lii_out_arbiter.sv
// Round-robin arbiter sharing one LII output channel between N kernel streams, with per-beat src/dst stamping.
// Latency: one arbitration cycle per grant, then one cycle from requester handshake to the beat on m_*.
// Backpressure: only the current grantee sees ready, and only when the output register is empty or draining.
//
// Ports:
//   aclk, arst            clock; synchronous active-high reset
//   s_tdata/s_tvalid/s_dst requester streams, stream i at [i*PW +: PW] / bit i / [i*8 +: 8]
//   s_tready              one-hot (or zero) ready back to the grantee
//   m_tdata/m_tvalid/m_tready  registered phy output channel
//   m_src, m_dst          constant source id and destination id of the beat on m_tdata
//   grant_idx, busy       current or most recent grantee; high while a grant is held
module lii_out_arbiter #(
    parameter int          N      = 4,
    parameter int          PW     = 128,
    parameter int          BURST  = 16,
    parameter logic [7:0]  SRC_ID = 8'h00,
    parameter int          GW     = $clog2(N)
) (
    input  logic              aclk,
    input  logic              arst,
    input  logic [N*PW-1:0]   s_tdata,
    input  logic [N-1:0]      s_tvalid,
    output logic [N-1:0]      s_tready,
    input  logic [N*8-1:0]    s_dst,
    output logic [PW-1:0]     m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [7:0]        m_src,
    output logic [7:0]        m_dst,
    output logic [GW-1:0]     grant_idx,
    output logic              busy
);

    localparam int CW = $clog2(BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [GW-1:0]   last_grant;
    logic [CW-1:0]   beat_cnt;

    // Arbitration scan results
    logic [GW-1:0]   cand;
    logic [GW-1:0]   arb_idx;
    logic            arb_found;

    // Grantee stream selected onto internal buses
    logic [PW-1:0]   sel_tdata;
    logic [7:0]      sel_dst;
    logic            sel_vld;

    logic            out_free;
    logic            xfer;
    logic            burst_end;

    // Output register can take a new beat when empty or when its beat leaves this cycle.
    assign out_free  = !m_tvalid || m_tready;
    assign xfer      = (state == GRANT) && sel_vld && out_free;
    assign burst_end = xfer && (beat_cnt == CW'(BURST - 1));

    assign busy  = (state == GRANT);
    assign m_src = SRC_ID;

    // Round-robin scan: first valid requester after last_grant, wrapping modulo N
    // (works for non-power-of-two N since the modulo is on the integer sum).
    always_comb begin
        cand      = '0;
        arb_idx   = '0;
        arb_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand = GW'((int'(last_grant) + k) % N);
            if (!arb_found && s_tvalid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // Grantee mux
    always_comb begin
        sel_vld   = 1'b0;
        sel_tdata = '0;
        sel_dst   = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == GW'(i)) begin
                sel_vld   = s_tvalid[i];
                sel_tdata = s_tdata[i*PW +: PW];
                sel_dst   = s_dst[i*8 +: 8];
            end
        end
    end

    // Next-state and ready generation
    always_comb begin
        state_nxt = state;
        s_tready  = '0;
        case (state)
            IDLE: begin
                if (arb_found) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                s_tready[grant_idx] = out_free;
                // A dropped valid releases immediately (bubble release); a stall with
                // valid held keeps the grant and does not advance beat_cnt.
                if (!sel_vld || burst_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            state      <= IDLE;
            last_grant <= GW'(N - 1);
            grant_idx  <= '0;
            beat_cnt   <= '0;
            m_tvalid   <= 1'b0;
            m_tdata    <= '0;
            m_dst      <= '0;
        end else begin
            state <= state_nxt;

            if ((state == IDLE) && arb_found) begin
                grant_idx <= arb_idx;
                beat_cnt  <= '0;
            end else if (xfer) begin
                beat_cnt <= beat_cnt + 1'b1;
            end

            if ((state == GRANT) && (state_nxt == IDLE)) begin
                last_grant <= grant_idx;
            end

            if (xfer) begin
                m_tvalid <= 1'b1;
                m_tdata  <= sel_tdata;
                m_dst    <= sel_dst;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end
        end
    end

endmodule
